// File: rtl/fact_pkg.sv
// Shared constants for the factorial MMIO front end: register map, FSM encoding
// and the default completion timeout.
package fact_pkg;

   localparam logic [1:0] ADDR_N      = 2'd0;
   localparam logic [1:0] ADDR_GO     = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_RESULT = 2'd3;

   localparam int DEFAULT_TIMEOUT = 255;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GO   = 2'd1,
      WAIT = 2'd2
   } fact_state_e;

endpackage

// File: rtl/fact_mmio_if.sv
// Bus-facing register block that launches one factorial request at a time and
// captures the core's result, error flag, or a timeout into sticky status.
module fact_mmio_if
   import fact_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        WE,
   input  logic [1:0]  A,
   input  logic [31:0] WD,
   output logic [31:0] RD,
   output logic        fGo,
   output logic [3:0]  fN,
   input  logic        fDone,
   input  logic        fErr,
   input  logic [31:0] fNF,
   output logic        Busy
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   fact_state_e state;
   logic [3:0]  nReg;
   logic [31:0] resultReg;
   logic        doneS;
   logic        errS;
   logic [7:0]  waitCnt;
   logic        prevDone;
   logic        doneRise;
   logic        goWrite;
   logic        unusedWd;

   assign unusedWd = ^WD[31:4];
   assign fN       = nReg;
   assign goWrite  = WE && (A == ADDR_GO) && WD[0];
   // Only a fresh edge completes a request, so a done level left over from the
   // previous run cannot finish the next one early.
   assign doneRise = fDone && !prevDone;

   always_comb begin
      RD = 32'd0;
      unique case (A)
         ADDR_N:      RD = {28'd0, nReg};
         ADDR_GO:     RD = {31'd0, Busy};
         ADDR_STATUS: RD = {30'd0, errS, doneS};
         ADDR_RESULT: RD = resultReg;
         default:     RD = 32'd0;
      endcase
   end

   // Request FSM with registered fGo/Busy; a real completion edge wins over a
   // timeout landing in the same cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         nReg      <= 4'd0;
         resultReg <= 32'd0;
         doneS     <= 1'b0;
         errS      <= 1'b0;
         waitCnt   <= 8'd0;
         prevDone  <= 1'b0;
         fGo       <= 1'b0;
         Busy      <= 1'b0;
      end else begin
         prevDone <= fDone;
         if (WE && (A == ADDR_N) && !Busy) begin
            nReg <= WD[3:0];
         end
         unique case (state)
            IDLE: begin
               if (goWrite) begin
                  state <= GO;
                  doneS <= 1'b0;
                  errS  <= 1'b0;
                  fGo   <= 1'b1;
                  Busy  <= 1'b1;
               end
            end
            GO: begin
               state   <= WAIT;
               fGo     <= 1'b0;
               waitCnt <= 8'd0;
            end
            WAIT: begin
               if (doneRise) begin
                  resultReg <= fNF;
                  errS      <= fErr;
                  doneS     <= 1'b1;
                  state     <= IDLE;
                  Busy      <= 1'b0;
               end else if (waitCnt == TIMEOUT_LAST) begin
                  resultReg <= 32'd0;
                  errS      <= 1'b1;
                  doneS     <= 1'b1;
                  state     <= IDLE;
                  Busy      <= 1'b0;
               end else begin
                  waitCnt <= waitCnt + 8'd1;
               end
            end
            default: begin
               state <= IDLE;
               fGo   <= 1'b0;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fact_mmio_if.sv
// Scoreboard bench for fact_mmio_if: stimulus queues expected values, a negedge
// monitor samples the selected DUT output and compares.
module tb_fact_mmio_if;

   localparam logic [1:0] ADR_N      = 2'd0;
   localparam logic [1:0] ADR_GO     = 2'd1;
   localparam logic [1:0] ADR_STATUS = 2'd2;
   localparam logic [1:0] ADR_RESULT = 2'd3;

   localparam int SEL_RD    = 0;
   localparam int SEL_FGO   = 1;
   localparam int SEL_BUSY  = 2;
   localparam int SEL_FN    = 3;
   localparam int SEL_GOCNT = 4;

   typedef struct {
      int          sel;
      logic [31:0] exp;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        WE  = 1'b0;
   logic [1:0]  A   = 2'd0;
   logic [31:0] WD  = 32'd0;
   logic [31:0] RD;
   logic        fGo;
   logic [3:0]  fN;
   logic        fDone = 1'b0;
   logic        fErr  = 1'b0;
   logic [31:0] fNF   = 32'd0;
   logic        Busy;

   exp_t  expQ[$];
   string nameQ[$];
   logic  chkReq = 1'b0;
   int    goCount = 0;
   int    total = 0;
   int    bad = 0;
   int    lat;

   fact_mmio_if #(.TIMEOUT(255)) dut (
      .CLK(CLK), .RST(RST), .WE(WE), .A(A), .WD(WD), .RD(RD),
      .fGo(fGo), .fN(fN), .fDone(fDone), .fErr(fErr), .fNF(fNF), .Busy(Busy)
   );

   always #5 CLK = ~CLK;

   // fGo is registered, so at each edge this sees the level of the cycle just ended.
   always @(posedge CLK) begin
      if (fGo) goCount <= goCount + 1;
   end

   always @(negedge CLK) begin
      if (chkReq) begin
         exp_t        e;
         string       n;
         logic [31:0] act;
         total++;
         if (expQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_underflow actual=empty required=entry");
         end else begin
            e = expQ.pop_front();
            n = nameQ.pop_front();
            case (e.sel)
               SEL_RD:    act = RD;
               SEL_FGO:   act = {31'd0, fGo};
               SEL_BUSY:  act = {31'd0, Busy};
               SEL_FN:    act = {28'd0, fN};
               SEL_GOCNT: act = 32'(goCount);
               default:   act = 32'hxxxx_xxxx;
            endcase
            if (act !== e.exp) begin
               bad++;
               $display("[TB] FAIL %s actual=0x%0h required=0x%0h", n, act, e.exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic we, input logic [1:0] adr, input logic [31:0] wd);
      WE = we;
      A  = adr;
      WD = wd;
      @(posedge CLK);
      #1;
      WE = 1'b0;
   endtask

   task automatic checkOutput(input int sel, input logic [1:0] adr, input logic [31:0] exp,
                              input string name);
      WE = 1'b0;
      A  = adr;
      expQ.push_back('{sel, exp});
      nameQ.push_back(name);
      chkReq = 1'b1;
      @(posedge CLK);
      #1;
      chkReq = 1'b0;
   endtask

   task automatic coreRespond(input logic err, input logic [31:0] nf);
      fErr  = err;
      fNF   = nf;
      fDone = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   task automatic coreIdle();
      fDone = 1'b0;
      fErr  = 1'b0;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      $display("[TB] start");
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;

      checkOutput(SEL_RD, ADR_N, 32'd0, "rst_n");
      checkOutput(SEL_RD, ADR_GO, 32'd0, "rst_go");
      checkOutput(SEL_RD, ADR_STATUS, 32'd0, "rst_status");
      checkOutput(SEL_RD, ADR_RESULT, 32'd0, "rst_result");
      checkOutput(SEL_FGO, ADR_N, 32'd0, "rst_fgo");
      checkOutput(SEL_BUSY, ADR_N, 32'd0, "rst_busy");

      RST = 1'b1;
      applyStimulus(1'b1, ADR_N, 32'd9);
      RST = 1'b0;
      checkOutput(SEL_RD, ADR_N, 32'd0, "rst_over_write");

      // 5! = 120
      applyStimulus(1'b1, ADR_N, 32'd5);
      checkOutput(SEL_RD, ADR_N, 32'd5, "t1_n");
      checkOutput(SEL_FN, ADR_N, 32'd5, "t1_fn");
      applyStimulus(1'b1, ADR_GO, 32'd1);
      checkOutput(SEL_FGO, ADR_N, 32'd1, "t1_fgo_high");
      checkOutput(SEL_FGO, ADR_N, 32'd0, "t1_fgo_low");
      checkOutput(SEL_RD, ADR_GO, 32'd1, "t1_go_reads_busy");
      coreRespond(1'b0, 32'd120);
      checkOutput(SEL_RD, ADR_STATUS, 32'h1, "t1_status");
      checkOutput(SEL_RD, ADR_RESULT, 32'h78, "t1_result");
      checkOutput(SEL_BUSY, ADR_N, 32'd0, "t1_busy");
      checkOutput(SEL_GOCNT, ADR_N, 32'd1, "t1_gocount");
      coreIdle();

      // n=13 overflows: core flags error alongside done
      applyStimulus(1'b1, ADR_N, 32'd13);
      checkOutput(SEL_FN, ADR_N, 32'd13, "t2_fn");
      applyStimulus(1'b1, ADR_GO, 32'd1);
      checkOutput(SEL_FGO, ADR_N, 32'd1, "t2_fgo_high");
      coreRespond(1'b1, 32'h1234_5678);
      checkOutput(SEL_RD, ADR_STATUS, 32'h3, "t2_status");
      checkOutput(SEL_RD, ADR_RESULT, 32'h1234_5678, "t2_result");
      coreIdle();

      // 0! = 1, then a second run with fDone still high from the first
      applyStimulus(1'b1, ADR_N, 32'd0);
      applyStimulus(1'b1, ADR_GO, 32'd1);
      checkOutput(SEL_FGO, ADR_N, 32'd1, "t3a_fgo_high");
      coreRespond(1'b0, 32'd1);
      checkOutput(SEL_RD, ADR_RESULT, 32'd1, "t3a_result");
      checkOutput(SEL_RD, ADR_STATUS, 32'h1, "t3a_status");
      fNF = 32'hDEAD_0000;
      applyStimulus(1'b1, ADR_GO, 32'd1);
      checkOutput(SEL_FGO, ADR_N, 32'd1, "t3b_fgo_high");
      checkOutput(SEL_RD, ADR_STATUS, 32'h0, "t3b_status_cleared");
      checkOutput(SEL_BUSY, ADR_N, 32'd1, "t3b_busy_held_done");
      checkOutput(SEL_RD, ADR_STATUS, 32'h0, "t3b_status_held_done");
      checkOutput(SEL_BUSY, ADR_N, 32'd1, "t3b_busy_held_done2");
      coreIdle();
      coreRespond(1'b0, 32'd1);
      checkOutput(SEL_RD, ADR_RESULT, 32'd1, "t3b_result");
      checkOutput(SEL_RD, ADR_STATUS, 32'h1, "t3b_status");
      checkOutput(SEL_GOCNT, ADR_N, 32'd4, "t3_gocount");
      coreIdle();

      // 3! = 6 with GO and N writes attempted while waiting
      applyStimulus(1'b1, ADR_N, 32'd3);
      applyStimulus(1'b1, ADR_GO, 32'd1);
      checkOutput(SEL_FGO, ADR_N, 32'd1, "t4_fgo_high");
      applyStimulus(1'b1, ADR_GO, 32'd1);
      applyStimulus(1'b1, ADR_N, 32'd7);
      checkOutput(SEL_FN, ADR_N, 32'd3, "t4_fn_unchanged");
      checkOutput(SEL_RD, ADR_N, 32'd3, "t4_n_unchanged");
      checkOutput(SEL_GOCNT, ADR_N, 32'd5, "t4_no_second_go");
      checkOutput(SEL_BUSY, ADR_N, 32'd1, "t4_busy");
      coreRespond(1'b0, 32'd6);
      checkOutput(SEL_RD, ADR_RESULT, 32'd6, "t4_result");
      checkOutput(SEL_RD, ADR_STATUS, 32'h1, "t4_status");
      coreIdle();

      // Core never answers: 1 GO cycle + 255 WAIT cycles before Busy drops
      applyStimulus(1'b1, ADR_N, 32'd2);
      applyStimulus(1'b1, ADR_GO, 32'd1);
      lat = 0;
      for (int i = 1; i <= 300; i++) begin
         @(posedge CLK);
         #1;
         if (!Busy) begin
            lat = i;
            break;
         end
      end
      total++;
      if (lat != 256) begin
         bad++;
         $display("[TB] FAIL timeout_cycles actual=%0d required=256", lat);
      end
      checkOutput(SEL_RD, ADR_STATUS, 32'h3, "t5_status");
      checkOutput(SEL_RD, ADR_RESULT, 32'd0, "t5_result");
      checkOutput(SEL_BUSY, ADR_N, 32'd0, "t5_busy");
      checkOutput(SEL_GOCNT, ADR_N, 32'd6, "t5_gocount");

      // Reset in the middle of WAIT; a later done edge must be ignored
      applyStimulus(1'b1, ADR_N, 32'd5);
      applyStimulus(1'b1, ADR_GO, 32'd1);
      checkOutput(SEL_FGO, ADR_N, 32'd1, "t6_fgo_high");
      checkOutput(SEL_BUSY, ADR_N, 32'd1, "t6_busy_wait");
      RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      checkOutput(SEL_RD, ADR_N, 32'd0, "t6_n");
      checkOutput(SEL_RD, ADR_GO, 32'd0, "t6_go");
      checkOutput(SEL_RD, ADR_STATUS, 32'd0, "t6_status");
      checkOutput(SEL_RD, ADR_RESULT, 32'd0, "t6_result");
      checkOutput(SEL_FGO, ADR_N, 32'd0, "t6_fgo");
      coreRespond(1'b0, 32'd120);
      checkOutput(SEL_RD, ADR_STATUS, 32'd0, "t6_status_after_done");
      checkOutput(SEL_RD, ADR_RESULT, 32'd0, "t6_result_after_done");
      checkOutput(SEL_BUSY, ADR_N, 32'd0, "t6_busy_after_done");
      coreIdle();

      if (expQ.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL scoreboard_leftover actual=%0d required=0", expQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fact_mmio_if.md
FACT_MMIO_IF -- requirements
Module: fact_mmio_if

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the maximum WAIT cycles before a forced error completion.
REQ-002 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port WE  input  1  bus write enable.
REQ-005 SHALL have port A  input  2  register word address.
REQ-006 SHALL have port WD  input  32  bus write data.
REQ-007 SHALL have port RD  output  32  bus read data.
REQ-008 SHALL have port fGo  output  1  start pulse to the factorial core.
REQ-009 SHALL have port fN  output  4  operand to the factorial core.
REQ-010 SHALL have port fDone  input  1  core done level.
REQ-011 SHALL have port fErr  input  1  core error level (n>12).
REQ-012 SHALL have port fNF  input  32  core result.
REQ-013 SHALL have port Busy  output  1  high while a request is outstanding.

Function
REQ-014 SHALL decode the following register map:
- A=0 N: read/write, bits[3:0]; writes ignored while Busy.
- A=1 GO: write with WD[0]=1 starts a request; reads return {31'b0, Busy}.
- A=2 STATUS: read-only, {30'b0, ErrS, DoneS}.
- A=3 RESULT: read-only, 32 bits.
REQ-015 SHALL drive RD combinationally from A, independent of WE.
REQ-016 SHALL implement FSM states IDLE, GO, WAIT.
REQ-017 SHALL move IDLE->GO on WE=1, A=1, WD[0]=1, and clear DoneS and ErrS on that same edge.
REQ-018 SHALL ignore GO writes in GO or WAIT, with no state change and no sticky-bit change.
REQ-019 SHALL assert fGo=1 for exactly one cycle, in state GO, then move to WAIT unconditionally.
REQ-020 SHALL drive fN continuously from the N register.
REQ-021 SHALL complete WAIT on a rising edge of fDone (fDone=1 with the registered previous fDone=0):
- RESULT<=fNF;
- ErrS<=fErr;
- DoneS<=1;
- go to IDLE.
REQ-022 SHALL not treat a fDone level held high from a prior run as completion.
REQ-023 SHALL run an 8-bit WAIT cycle counter, cleared on entry to WAIT.
REQ-024 SHALL, when the counter reaches TIMEOUT without completion, set RESULT<=0, ErrS<=1, DoneS<=1 and go to IDLE.
REQ-025 SHALL give completion priority when completion and timeout fall in the same cycle.
REQ-026 SHALL drive Busy=1 in GO and WAIT, and 0 in IDLE.
REQ-027 SHALL give bus-to-start latency of 1 cycle: the GO write edge enters GO, and fGo is high during the following cycle.
REQ-028 SHALL hold DoneS/ErrS sticky until the next accepted GO write or reset.
REQ-029 SHALL apply N writes and GO writes in the same cycle only in their respective address cycles; no other side effects.

Reset
REQ-030 SHALL, on RST=1 at a clock edge, apply the following regardless of state (including mid-WAIT):
- state<=IDLE;
- N<=0, RESULT<=0, DoneS<=0, ErrS<=0;
- counter<=0, previous-fDone register<=0.
REQ-031 SHALL hold fGo=0 and Busy=0 during and after reset until a new GO write.
REQ-032 SHALL give RST priority over a simultaneous bus write.

Structure
REQ-033 SHALL place register addresses (ADDR_N=0, ADDR_GO=1, ADDR_STATUS=2, ADDR_RESULT=3), FSM state encodings and the default TIMEOUT in a shared package, fact_pkg.
REQ-034 SHALL be a single module with no sub-modules; it instantiates alongside the factorial top, not inside it.

Verification
REQ-035 SHALL pass: write N=5, write GO=1, core completes -> one-cycle fGo, STATUS=0x1, RESULT=120 (0x78), Busy low.
REQ-036 SHALL pass: N=13, GO -> core raises fErr with fDone -> STATUS=0x3, RESULT=captured fNF.
REQ-037 SHALL pass: N=0, GO -> RESULT=1, STATUS=0x1; a second GO with fDone still high from the first run -> no completion until a new fDone rising edge.
REQ-038 SHALL pass: GO write and N=7 write during WAIT -> no second fGo, N unchanged, the original request completes normally.
REQ-039 SHALL pass: core never raises fDone -> after 255 WAIT cycles, STATUS=0x3, RESULT=0, Busy=0.
REQ-040 SHALL pass: RST asserted mid-WAIT -> next cycle all registers read 0, Busy=0, and a later fDone edge is ignored.
